// File: rtl/negator_pkg.sv
// Shared widths, counter ceiling and popcount helper for the negator datapath stage.
package negator_pkg;

  localparam int DEFAULT_LANE_WIDTH = 64;
  localparam int DEFAULT_NUM_LANES  = 1;
  localparam int OVF_COUNT_WIDTH    = 16;
  localparam int MAX_LANES          = 256;

  localparam logic [OVF_COUNT_WIDTH-1:0] OVF_COUNT_MAX = '1;

  // Result is one bit wider than the counter so a sum with the count cannot wrap.
  function automatic logic [OVF_COUNT_WIDTH:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [OVF_COUNT_WIDTH:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      cnt = cnt + (OVF_COUNT_WIDTH+1)'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/single_cycle_tightly_coupled_negator_lane.sv
// One lane: two's-complement negation plus most-negative detection, purely combinational.
module negator_lane #(
  parameter int LANE_WIDTH = 64
) (
  input  logic [LANE_WIDTH-1:0] operand,
  output logic [LANE_WIDTH-1:0] result,
  output logic                  most_neg
);

  localparam logic [LANE_WIDTH-1:0] MOST_NEG = {1'b1, {(LANE_WIDTH-1){1'b0}}};

  assign result   = ~operand + LANE_WIDTH'(1);
  assign most_neg = (operand == MOST_NEG);

endmodule

// File: rtl/single_cycle_tightly_coupled_negator.sv
// Zero-latency multi-lane negator; optional overflow monitor enabled by NEGATOR_OVF_MONITOR_EN.
// Without the macro the monitor outputs are tied low and clock/reset/in_valid are unused.
module single_cycle_tightly_coupled_negator
  import negator_pkg::*;
#(
  parameter int NUM_LANES  = DEFAULT_NUM_LANES,
  parameter int LANE_WIDTH = DEFAULT_LANE_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data,
  output logic [NUM_LANES*LANE_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            lane_ovf,
  output logic                            ovf_sticky,
  output logic [OVF_COUNT_WIDTH-1:0]      ovf_count
);

  logic [NUM_LANES-1:0] lane_min;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    negator_lane #(.LANE_WIDTH(LANE_WIDTH)) u_lane (
      .operand  (in_data[i*LANE_WIDTH +: LANE_WIDTH]),
      .result   (out_data[i*LANE_WIDTH +: LANE_WIDTH]),
      .most_neg (lane_min[i])
    );
  end

`ifdef NEGATOR_OVF_MONITOR_EN
  logic [MAX_LANES-1:0]       ovf_vec;
  logic [OVF_COUNT_WIDTH:0]   count_sum;

  assign lane_ovf = lane_min;

  always_comb begin
    ovf_vec = '0;
    ovf_vec[NUM_LANES-1:0] = lane_min;
    count_sum = {1'b0, ovf_count} + popcount(ovf_vec);
  end

  // Reset has priority over a same-cycle overflow; the count clamps rather than wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (in_valid) begin
      ovf_sticky <= ovf_sticky | (|lane_min);
      ovf_count  <= (count_sum > {1'b0, OVF_COUNT_MAX}) ? OVF_COUNT_MAX
                                                        : count_sum[OVF_COUNT_WIDTH-1:0];
    end
  end
`else
  wire unused_monitor = &{1'b0, clock, reset, in_valid, lane_min};

  assign lane_ovf   = '0;
  assign ovf_sticky = 1'b0;
  assign ovf_count  = '0;
`endif

endmodule

// File: tb/tb_single_cycle_tightly_coupled_negator.sv
// Directed bench for the negator: single-lane default and two-lane instances side by side.
module tb_single_cycle_tightly_coupled_negator;

`ifdef NEGATOR_OVF_MONITOR_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  localparam logic [63:0] MN = 64'h8000_0000_0000_0000;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid, in_valid2;
  logic [63:0]  in_data, out_data;
  logic [127:0] in_data2, out_data2;
  logic [0:0]   lane_ovf;
  logic [1:0]   lane_ovf2;
  logic         ovf_sticky, ovf_sticky2;
  logic [15:0]  ovf_count, ovf_count2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  single_cycle_tightly_coupled_negator dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data), .lane_ovf(lane_ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  single_cycle_tightly_coupled_negator #(.NUM_LANES(2), .LANE_WIDTH(64)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid2), .in_data(in_data2),
    .out_data(out_data2), .lane_ovf(lane_ovf2), .ovf_sticky(ovf_sticky2), .ovf_count(ovf_count2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
    in_data = '0; in_data2 = '0;
    tick(2);
    reset = 1'b0;
    check("rst_sticky", 128'(ovf_sticky), 128'(0));
    check("rst_count",  128'(ovf_count),  128'(0));
    check("rst_count2", 128'(ovf_count2), 128'(0));

    in_data = 64'h5; #1;
    check("neg5",      128'(out_data), 128'(64'hFFFF_FFFF_FFFF_FFFB));
    check("neg5_ovf",  128'(lane_ovf), 128'(0));
    in_data = 64'h0; #1;
    check("neg0",      128'(out_data), 128'(0));
    in_data = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    check("negm1",     128'(out_data), 128'(1));
    in_data = 64'h0123_4567_89AB_CDEF; #1;
    check("negpat",    128'(out_data), 128'(64'hFEDC_BA98_7654_3211));

    // Overflow value with in_valid low: flag only, no monitor update.
    in_data = MN; in_valid = 1'b0; #1;
    check("mn_noval_out", 128'(out_data), 128'(MN));
    check("mn_noval_ovf", 128'(lane_ovf), 128'(EN));
    tick(1);
    check("noval_sticky", 128'(ovf_sticky), 128'(0));
    check("noval_count",  128'(ovf_count),  128'(0));

    in_valid = 1'b1; #1;
    check("mn_out", 128'(out_data), 128'(MN));
    check("mn_ovf", 128'(lane_ovf), 128'(EN));
    tick(1);
    in_valid = 1'b0; in_data = 64'h2;
    check("ovf_sticky", 128'(ovf_sticky), 128'(EN));
    check("ovf_count",  128'(ovf_count),  128'(EN ? 1 : 0));
    tick(3);
    check("hold_count", 128'(ovf_count),  128'(EN ? 1 : 0));

    // Two lanes: upper overflows, lower negates 1; no carry between lanes.
    in_data2 = {MN, 64'h1}; in_valid2 = 1'b1; #1;
    check("ml_out", out_data2, {MN, 64'hFFFF_FFFF_FFFF_FFFF});
    check("ml_ovf", 128'(lane_ovf2), 128'(EN ? 2'b10 : 2'b00));
    tick(1);
    in_valid2 = 1'b0;
    check("ml_count",  128'(ovf_count2),  128'(EN ? 1 : 0));
    check("ml_sticky", 128'(ovf_sticky2), 128'(EN));
    in_data2 = {64'h0000_0000_0000_0100, 64'hFFFF_FFFF_FFFF_FFFE}; #1;
    check("ml_out2", out_data2, {64'hFFFF_FFFF_FFFF_FF00, 64'h2});

    // Reset in the same cycle as qualified overflows: reset wins.
    reset = 1'b1; in_valid = 1'b1; in_data = MN;
    in_valid2 = 1'b1; in_data2 = {MN, MN}; #1;
    check("rst_out_track", 128'(out_data), 128'(MN));
    tick(1);
    reset = 1'b0;
    check("rstwin_count",  128'(ovf_count),   128'(0));
    check("rstwin_sticky", 128'(ovf_sticky),  128'(0));
    check("rstwin_count2", 128'(ovf_count2),  128'(0));

    // Saturation: single lane +1 per cycle, two lanes +2 per cycle.
    tick(32767);
    check("sat_mid_count",  128'(ovf_count),  128'(EN ? 16'h7FFF : 16'h0));
    check("sat_mid_count2", 128'(ovf_count2), 128'(EN ? 16'hFFFE : 16'h0));
    tick(1);
    check("clamp_count2",   128'(ovf_count2), 128'(EN ? 16'hFFFF : 16'h0));
    tick(32767);
    check("sat_reach",      128'(ovf_count),  128'(EN ? 16'hFFFF : 16'h0));
    tick(5);
    check("sat_hold",       128'(ovf_count),  128'(EN ? 16'hFFFF : 16'h0));
    check("sat_hold2",      128'(ovf_count2), 128'(EN ? 16'hFFFF : 16'h0));

    // One-cycle reset; data path keeps tracking input throughout.
    reset = 1'b1; in_data = 64'h7; #1;
    check("rst_out", 128'(out_data), 128'(64'hFFFF_FFFF_FFFF_FFF9));
    tick(1);
    reset = 1'b0;
    check("sat_rst_count",  128'(ovf_count),  128'(0));
    check("sat_rst_sticky", 128'(ovf_sticky), 128'(0));
    check("sat_rst_count2", 128'(ovf_count2), 128'(0));
    in_data = 64'h8; #1;
    check("post_rst_out", 128'(out_data), 128'(64'hFFFF_FFFF_FFFF_FFF8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/single_cycle_tightly_coupled_negator.md
# single_cycle_tightly_coupled_negator

Zero-latency arithmetic negator used as the compute stage of the tightly-coupled encrypted datapath, between the decrypt and encrypt engines. It negates each packed integer lane of its input in two's complement within the same cycle. An optional overflow monitor flags most-negative inputs and keeps sticky and count state.

## Interface
Parameters:
- NUM_LANES, default 1, number of integers processed per cycle.
- LANE_WIDTH, default 64, bit width of each integer.

Ports:
- clock  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  qualifies in_data for the overflow monitor only; tie to 1 if unused.
- in_data  input  NUM_LANES*LANE_WIDTH  packed operands; lane i occupies bits [i*LANE_WIDTH +: LANE_WIDTH].
- out_data  output  NUM_LANES*LANE_WIDTH  packed negated results, with the same lane packing.
- lane_ovf  output  NUM_LANES  per-lane combinational flag: the lane input equals the most-negative value.
- ovf_sticky  output  1  registered; set once any qualified lane overflows.
- ovf_count  output  16  registered saturating count of qualified overflowing lanes.

## Operation
- Per lane: out = (~in + 1) mod 2^LANE_WIDTH. The result wraps, with no saturation.
- 0 maps to 0.
- The most-negative value (MSB=1, all other bits 0) maps to itself and asserts lane_ovf[i].
- Lanes are fully independent, with no carry between lanes.
- Each cycle with in_valid=1:
  - ovf_sticky <= ovf_sticky | (|lane_ovf).
  - ovf_count <= min(ovf_count + popcount(lane_ovf), 16'hFFFF).
- in_valid=0: monitor state holds. out_data and lane_ovf are still driven from in_data.
- A lane with X or unknown input requires no defined behaviour beyond propagating X.

## Timing
- out_data and lane_ovf are purely combinational from in_data, so latency is 0 cycles. There is no register on the data path.
- The surrounding datapath samples the result in the same cycle it drives the operand.
- ovf_sticky and ovf_count update on the rising clock edge.
- Reset values: ovf_sticky=0, ovf_count=0.
- reset does not gate out_data or lane_ovf; they continue to follow in_data during reset.
- Reset asserted in the same cycle as an overflow: reset wins, and the registers read 0 on the next cycle.
- Count saturation:
  - At 16'hFFFF, further overflows leave the count at 16'hFFFF.
  - With NUM_LANES>1, an increment that would exceed the ceiling clamps to 16'hFFFF.

## Configuration
- Macro NEGATOR_OVF_MONITOR_EN.
- Defined: lane_ovf, ovf_sticky and ovf_count behave as above.
- Undefined:
  - lane_ovf, ovf_sticky and ovf_count are tied to 0, and no monitor flops are inferred.
  - in_valid, clock and reset are unused.
  - out_data is unchanged.

## Structure
- Package negator_pkg holds:
  - the default widths: DEFAULT_LANE_WIDTH=64, DEFAULT_NUM_LANES=1, OVF_COUNT_WIDTH=16;
  - the OVF_COUNT_MAX constant;
  - a popcount function used for the lane_ovf summation.
- Sub-module negator_lane (parameter LANE_WIDTH) performs the negation and most-negative detection for one lane. The top level instantiates it NUM_LANES times in a generate loop and adds the monitor registers.

## Test plan
- Defaults (NUM_LANES=1, LANE_WIDTH=64):
  - in_data=64'h0000_0000_0000_0005 -> out_data=64'hFFFF_FFFF_FFFF_FFFB in the same cycle; lane_ovf=0.
  - in_data=64'h0 -> out_data=64'h0.
  - in_data=64'hFFFF_FFFF_FFFF_FFFF -> out_data=64'h1.
- Overflow (defaults): in_data=64'h8000_0000_0000_0000, in_valid=1 for one cycle -> out_data=64'h8000_0000_0000_0000 and lane_ovf=1 in that cycle. On the next cycle ovf_sticky=1 and ovf_count=1.
- Same overflow input with in_valid=0 -> lane_ovf=1, but ovf_sticky and ovf_count stay 0.
- Multi-lane (NUM_LANES=2, LANE_WIDTH=64): in_data={64'h8000_0000_0000_0000, 64'h1}, in_valid=1:
  - out_data={64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
  - lane_ovf=2'b10;
  - ovf_count increments by 1.
- Saturation and reset:
  - Hold an overflow input with in_valid=1 for 65,540 cycles -> ovf_count stops at 16'hFFFF.
  - Then assert reset for one cycle -> ovf_count=0 and ovf_sticky=0 on the next cycle, while out_data still tracks in_data throughout.
